param_adder: RTL and testbench

- Parameterized, pipelined unsigned adder: o_w_s = i_w_a + i_w_b, with full carry-out preserved (output is one bit wider than the operands).
- Operands are p_width+1 bits wide (bit range [p_width:0]).
- Generic arithmetic leaf used wherever a width-configurable registered sum is needed.
- Carry chain is split across p_stages register stages for timing.

---
 rtl/param_adder_pkg.sv | 18 +
 rtl/param_adder_slice.sv | 16 +
 rtl/param_adder.sv | 98 +++++++++
 tb/tb_param_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/param_adder_pkg.sv
// Shared constants and helpers for the pipelined adder:
// chunk sizing and the legal stage-count check.
package param_adder_pkg;

  localparam int unsigned c_min_stages = 1;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  // Stages are bounded by the operand width so every chunk is at least one bit wide.
  function automatic bit stages_legal(input int unsigned width,
                                      input int unsigned stages);
    return (stages >= c_min_stages) && (stages <= width);
  endfunction

endpackage

// File: rtl/param_adder_slice.sv
// Combinational chunk adder: one carry-chain segment of the pipelined adder.
module param_adder_slice
  import param_adder_pkg::*;
#(
  parameter int unsigned p_chunk_w = 1
) (
  input  logic [p_chunk_w-1:0] a,
  input  logic [p_chunk_w-1:0] b,
  input  logic                 cin,
  output logic [p_chunk_w-1:0] sum,
  output logic                 cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{p_chunk_w{1'b0}}, cin};

endmodule

// File: rtl/param_adder.sv
// Pipelined unsigned adder: o_w_s = i_w_a + i_w_b with full carry-out,
// carry chain split over p_stages registered chunks, LSB chunk first.
module param_adder
  import param_adder_pkg::*;
#(
  parameter int unsigned p_width  = 6,
  parameter int unsigned p_stages = 1
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  input  logic               i_w_valid,
  input  logic [p_width:0]   i_w_a,
  input  logic [p_width:0]   i_w_b,
  output logic               o_w_valid,
  output logic [p_width+1:0] o_w_s
);

  localparam int unsigned c_w  = p_width + 1;
  localparam int unsigned c_cw = chunk_width(c_w, p_stages);
  localparam int unsigned c_pw = c_cw * p_stages;

  if (!stages_legal(c_w, p_stages)) begin : g_bad_stages
    $error("param_adder: p_stages must lie in 1..p_width+1");
  end

  // Operands are zero-padded to a whole number of chunks, so the top chunk
  // is effectively the narrower one and the real carry lands in bit c_w.
  logic [c_pw-1:0] a_pipe [p_stages];
  logic [c_pw-1:0] b_pipe [p_stages];
  logic [c_pw-1:0] s_pipe [p_stages];
  logic            c_pipe [p_stages];
  logic            v_pipe [p_stages];

  for (genvar k = 0; k < p_stages; k++) begin : g_stage
    logic [c_pw-1:0] a_in;
    logic [c_pw-1:0] b_in;
    logic [c_pw-1:0] s_in;
    logic [c_pw-1:0] s_out;
    logic            c_in;
    logic            v_in;
    logic [c_cw-1:0] sum;
    logic            cout;

    if (k == 0) begin : g_first
      assign a_in = c_pw'(i_w_a);
      assign b_in = c_pw'(i_w_b);
      assign s_in = '0;
      assign c_in = 1'b0;
      assign v_in = i_w_valid;
    end else begin : g_next
      assign a_in = a_pipe[k-1];
      assign b_in = b_pipe[k-1];
      assign s_in = s_pipe[k-1];
      assign c_in = c_pipe[k-1];
      assign v_in = v_pipe[k-1];
    end

    param_adder_slice #(
      .p_chunk_w(c_cw)
    ) u_slice (
      .a   (a_in[k*c_cw +: c_cw]),
      .b   (b_in[k*c_cw +: c_cw]),
      .cin (c_in),
      .sum (sum),
      .cout(cout)
    );

    always_comb begin
      s_out = s_in;
      s_out[k*c_cw +: c_cw] = sum;
    end

    always_ff @(posedge i_w_clk) begin
      if (i_w_reset) begin
        a_pipe[k] <= '0;
        b_pipe[k] <= '0;
        s_pipe[k] <= '0;
        c_pipe[k] <= 1'b0;
        v_pipe[k] <= 1'b0;
      end else begin
        a_pipe[k] <= a_in;
        b_pipe[k] <= b_in;
        s_pipe[k] <= s_out;
        c_pipe[k] <= cout;
        v_pipe[k] <= v_in;
      end
    end
  end

  if (c_pw == c_w) begin : g_exact
    assign o_w_s = {c_pipe[p_stages-1], s_pipe[p_stages-1][c_w-1:0]};
  end else begin : g_padded
    assign o_w_s = s_pipe[p_stages-1][c_w:0];
  end

  assign o_w_valid = v_pipe[p_stages-1];

endmodule

// File: tb/tb_param_adder.sv
// Bench for param_adder: several width/stage configurations driven in lockstep,
// checked against a queue of expected sums and an expected-valid history.
module tb_param_adder;

  localparam int N = 5;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp_w6;
    logic [16:0] exp_w0;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [15:0] a;
  logic [15:0] b;

  logic        v0, v1, v2, v3, v4;
  logic [7:0]  s0, s1, s4;
  logic [1:0]  s2;
  logic [16:0] s3;

  logic        ov [N];
  logic [16:0] os [N];

  int          wid [N];
  int          lat [N];
  int          first_seen [N];
  logic [16:0] sb [N][$];
  logic [7:0]  vh;
  int          checks;
  int          errors;
  int          step_no;
  vec_t        vecs [10];

  always #5 clk = ~clk;

  param_adder #(.p_width(6), .p_stages(1)) u_w6s1 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_valid(valid),
    .i_w_a(a[6:0]), .i_w_b(b[6:0]), .o_w_valid(v0), .o_w_s(s0));
  param_adder #(.p_width(6), .p_stages(3)) u_w6s3 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_valid(valid),
    .i_w_a(a[6:0]), .i_w_b(b[6:0]), .o_w_valid(v1), .o_w_s(s1));
  param_adder #(.p_width(0), .p_stages(1)) u_w0s1 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_valid(valid),
    .i_w_a(a[0:0]), .i_w_b(b[0:0]), .o_w_valid(v2), .o_w_s(s2));
  param_adder #(.p_width(15), .p_stages(4)) u_w15s4 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_valid(valid),
    .i_w_a(a), .i_w_b(b), .o_w_valid(v3), .o_w_s(s3));
  param_adder #(.p_width(6), .p_stages(5)) u_w6s5 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_valid(valid),
    .i_w_a(a[6:0]), .i_w_b(b[6:0]), .o_w_valid(v4), .o_w_s(s4));

  assign ov[0] = v0;
  assign ov[1] = v1;
  assign ov[2] = v2;
  assign ov[3] = v3;
  assign ov[4] = v4;
  assign os[0] = 17'(s0);
  assign os[1] = 17'(s1);
  assign os[2] = 17'(s2);
  assign os[3] = s3;
  assign os[4] = 17'(s4);

  function automatic logic [16:0] model(input int w, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] mask;
    mask = (17'd1 << w) - 17'd1;
    return (17'(x) & mask) + (17'(y) & mask);
  endfunction

  task automatic chk(input string name, input int i, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %0d want %0d", name, i, got, want);
    end
  endtask

  task automatic step(input logic [15:0] ta, input logic [15:0] tb, input logic tv, input logic tr);
    a = ta;
    b = tb;
    valid = tv;
    reset = tr;
    if (tv && !tr)
      for (int i = 0; i < N; i++) sb[i].push_back(model(wid[i], ta, tb));
    vh = {vh[6:0], tv && !tr};
    @(posedge clk);
    if (tr) begin
      for (int i = 0; i < N; i++) sb[i].delete();
      vh = '0;
    end
    #1;
    step_no++;
    for (int i = 0; i < N; i++) begin
      chk("valid", i, 17'(ov[i]), 17'(vh[lat[i]-1]));
      if (tr) chk("rst_sum", i, os[i], 17'd0);
      if (ov[i] === 1'b1) begin
        if (first_seen[i] < 0) first_seen[i] = step_no;
        if (sb[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result dut%0d got %0d want none", i, os[i]);
        end else begin
          chk("sum", i, os[i], sb[i].pop_front());
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    step_no = 0;
    vh = '0;
    wid = '{7, 7, 1, 16, 7};
    lat = '{1, 3, 1, 4, 5};
    for (int i = 0; i < N; i++) first_seen[i] = -1;
    a = '0;
    b = '0;
    valid = 1'b0;
    reset = 1'b1;

    step(16'd0, 16'd0, 1'b0, 1'b1);
    step(16'd0, 16'd0, 1'b1, 1'b1);

    vecs[0] = '{16'd15,  16'd15,  17'd30,  17'd2};
    vecs[1] = '{16'd127, 16'd1,   17'd128, 17'd2};
    vecs[2] = '{16'd127, 16'd127, 17'd254, 17'd2};
    vecs[3] = '{16'd0,   16'd0,   17'd0,   17'd0};
    vecs[4] = '{16'd100, 16'd27,  17'd127, 17'd1};
    vecs[5] = '{16'd7,   16'd1,   17'd8,   17'd2};
    vecs[6] = '{16'd64,  16'd64,  17'd128, 17'd0};
    vecs[7] = '{16'd85,  16'd42,  17'd127, 17'd1};
    vecs[8] = '{16'd1,   16'd126, 17'd127, 17'd1};
    vecs[9] = '{16'd126, 16'd2,   17'd128, 17'd0};
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].a, vecs[v].b, 1'b1, 1'b0);
      chk("table_w6", 0, os[0], vecs[v].exp_w6);
      chk("table_w0", 2, os[2], vecs[v].exp_w0);
    end

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        step(16'(ia), 16'(ib), 1'b1, 1'b0);

    // Single pulse: each configuration must emit it exactly lat[i] samples later.
    for (int k = 0; k < 6; k++) step(16'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) first_seen[i] = -1;
    begin
      int base;
      base = step_no;
      step(16'd100, 16'd27, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) step(16'd0, 16'd0, 1'b0, 1'b0);
      for (int i = 0; i < N; i++)
        chk("latency", i, 17'(first_seen[i] - base), 17'(lat[i]));
    end

    for (int k = 0; k < 200; k++)
      step(16'($urandom), 16'($urandom), (k % 2) == 0, 1'b0);

    for (int k = 0; k < 6; k++) step(16'($urandom), 16'($urandom), 1'b1, 1'b0);
    step(16'($urandom), 16'($urandom), 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) step(16'd0, 16'd0, 1'b0, 1'b0);

    step(16'd5, 16'd6, 1'b1, 1'b1);
    step(16'd9, 16'd9, 1'b1, 1'b0);
    step(16'hffff, 16'hffff, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step(16'd0, 16'd0, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) begin
      checks++;
      if (sb[i].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d got %0d pending want 0", i, sb[i].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
